// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and FSM state definitions shared by the ALU, alu_seq and the decoder
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_AND = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_iter.sv
// rtl/alu_seq_iter.sv - iterative 1-bit/cycle shifter and shift-add multiplier (low half)
module alu_seq_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_step;

  always_comb begin
    acc_step = acc_q;
    case (op_q)
      OP_SLL:  acc_step = acc_q << 1;
      OP_SRL:  acc_step = acc_q >> 1;
      OP_MUL:  if (mplier_q[0]) acc_step = acc_q + mcand_q;
      default: acc_step = acc_q;
    endcase
  end

  always_comb begin
    op_d     = op_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start) begin
      op_d   = op;
      busy_d = 1'b1;
      if (op == OP_MUL) begin
        cnt_d    = CW'(WIDTH);
        acc_d    = '0;
        mcand_d  = a;
        mplier_d = b;
      end else begin
        cnt_d = {1'b0, b[SHW-1:0]};
        acc_d = a;
      end
    end else if (busy_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q     <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  // The final step's value is presented combinationally so the top can
  // register it on the same edge that ends BUSY.
  assign busy   = busy_q;
  assign done   = busy_q && (cnt_q == CW'(1));
  assign result = acc_step;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU with valid/ready handshake and registered flags
// ALU_SEQ_BARREL_SHIFT_EN: shifts computed at accept (latency 1) instead of iteratively.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             sign_flag,
  output logic             carry_flag,
  output logic             ovf_flag
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             sign_q, sign_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry, alu_ovf, multi;

  logic             iter_start, iter_busy, iter_done;
  logic [WIDTH-1:0] iter_result;

  assign shamt = b[SHW-1:0];

  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} - {1'b0, b};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    multi     = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // diff[WIDTH] is the borrow, i.e. a < b unsigned
        alu_res   = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];
        alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
`ifdef ALU_SEQ_BARREL_SHIFT_EN
      OP_SLL: alu_res = a << shamt;
      OP_SRL: alu_res = a >> shamt;
`else
      OP_SLL, OP_SRL: begin
        alu_res = a;
        multi   = (shamt != '0);
      end
`endif
      OP_MUL: multi = 1'b1;
      OP_XOR: alu_res = a ^ b;
      OP_OR:  alu_res = a | b;
      default: alu_res = a & b;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    zero_d     = zero_q;
    sign_d     = sign_q;
    carry_d    = carry_q;
    ovf_d      = ovf_q;
    iter_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (multi) begin
            iter_start = 1'b1;
            state_d    = ST_BUSY;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            sign_d   = alu_res[WIDTH-1];
            carry_d  = alu_carry;
            ovf_d    = alu_ovf;
            state_d  = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (iter_busy && iter_done) begin
          result_d = iter_result;
          zero_d   = (iter_result == '0);
          sign_d   = iter_result[WIDTH-1];
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      sign_q   <= sign_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (iter_start),
    .op     (opcode),
    .a      (a),
    .b      (b),
    .busy   (iter_busy),
    .done   (iter_done),
    .result (iter_result)
  );

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign result     = result_q;
  assign zero_flag  = zero_q;
  assign sign_flag  = sign_q;
  assign carry_flag = carry_q;
  assign ovf_flag   = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq against a behavioural reference model
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  opcode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero_flag;
  logic        sign_flag;
  logic        carry_flag;
  logic        ovf_flag;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .opcode     (opcode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero_flag  (zero_flag),
    .sign_flag  (sign_flag),
    .carry_flag (carry_flag),
    .ovf_flag   (ovf_flag)
  );

  // {result, zero, sign, carry, ovf} from the instruction-set rules
  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
    longint ux, uy, sx, sy, t;
    logic [31:0] r;
    logic c, v;
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin
        t = ux + uy; r = t[31:0]; c = (t > longint'(32'hFFFF_FFFF));
        t = sx + sy; v = (t > 2147483647) || (t < -2147483647 - 1);
      end
      3'd2: begin
        t = ux - uy; r = t[31:0]; c = (ux < uy);
        t = sx - sy; v = (t > 2147483647) || (t < -2147483647 - 1);
      end
      3'd3: begin t = ux * uy; r = t[31:0]; end
      3'd1: r = x << y[4:0];
      3'd5: r = x >> y[4:0];
      3'd4: r = x ^ y;
      3'd6: r = x | y;
      default: r = x & y;
    endcase
    return {r, (r == 32'd0), r[31], c, v};
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] y);
    if (op == 3'd3) return 33;
`ifdef ALU_SEQ_BARREL_SHIFT_EN
    return 1;
`else
    if ((op == 3'd1 || op == 3'd5) && y[4:0] != 5'd0) return int'(y[4:0]) + 1;
    return 1;
`endif
  endfunction

  // Presents one operation, scrambles the inputs after accept, and waits for out_valid.
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] iop,
                       output int lat, output logic [35:0] obs);
    @(negedge clk);
    in_valid = 1'b1; a = ia; b = ib; opcode = iop;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom; opcode = 3'($urandom);
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    obs = {result, zero_flag, sign_flag, carry_flag, ovf_flag};
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      fails++; $display("FAIL reset_hs got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    tests++;
    if ({result, zero_flag, sign_flag, carry_flag, ovf_flag} !== 36'd0) begin
      fails++; $display("FAIL reset_vals got %h %b%b%b%b want all 0", result, zero_flag, sign_flag, carry_flag, ovf_flag);
    end
  endtask

  task automatic test_directed(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] iop,
                               input logic [35:0] want, input int want_lat);
    int lat;
    logic [35:0] obs;
    issue(ia, ib, iop, lat, obs);
    tests++;
    if (lat !== want_lat) begin
      fails++; $display("FAIL dir_lat op=%0d got %0d want %0d", iop, lat, want_lat);
    end
    tests++;
    if (obs !== want) begin
      fails++; $display("FAIL dir_res op=%0d got %h want %h", iop, obs, want);
    end
    release_out();
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL dir_idle got in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_mul_stall();
    int lat;
    logic [35:0] obs;
    issue(32'h0001_0003, 32'h0002_0005, 3'd3, lat, obs);
    tests++;
    if (lat !== 33) begin
      fails++; $display("FAIL mul_lat got %0d want 33", lat);
    end
    tests++;
    if (obs !== {32'h000B_000F, 4'b0000}) begin
      fails++; $display("FAIL mul_res got %h want %h", obs, {32'h000B_000F, 4'b0000});
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if ({out_valid, in_ready, result} !== {2'b10, 32'h000B_000F}) begin
        fails++; $display("FAIL mul_stall cyc=%0d got v=%b r=%b res=%h want 1 0 000b000f", i, out_valid, in_ready, result);
      end
    end
    release_out();
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    logic [35:0] obs;
    @(negedge clk);
    in_valid = 1'b1; a = 32'h1234_5678; b = 32'h9ABC_DEF1; opcode = 3'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    tests++;
    if ({in_ready, out_valid} !== 2'b00) begin
      fails++; $display("FAIL mul_busy got in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if ({in_ready, out_valid, result} !== {2'b10, 32'd0}) begin
      fails++; $display("FAIL mid_rst got r=%b v=%b res=%h want 1 0 0", in_ready, out_valid, result);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++; $display("FAIL mid_rst_ghost got %0d out_valid cycles want 0", seen);
    end
    test_directed(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd7, {32'hF000_F000, 4'b0100}, 1);
    obs = '0;
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [35:0] obs;
    logic [31:0] x, y;
    x = $urandom; y = $urandom;
    issue(x, y, 3'd0, lat, obs);
    tests++;
    if (obs !== model(x, y, 3'd0)) begin
      fails++; $display("FAIL b2b_first got %h want %h", obs, model(x, y, 3'd0));
    end
    x = $urandom; y = $urandom;
    @(negedge clk);
    in_valid = 1'b1; a = x; b = y; opcode = 3'd4; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++; $display("FAIL b2b_noaccept got v=%b r=%b want 0 1", out_valid, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if ({out_valid, result, zero_flag, sign_flag, carry_flag, ovf_flag} !== {1'b1, model(x, y, 3'd4)}) begin
      fails++; $display("FAIL b2b_second got v=%b %h want 1 %h", out_valid,
                        {result, zero_flag, sign_flag, carry_flag, ovf_flag}, model(x, y, 3'd4));
    end
    release_out();
  endtask

  task automatic test_random();
    int lat;
    logic [35:0] obs;
    logic [31:0] x, y;
    logic [2:0]  op;
    for (int i = 0; i < 60; i++) begin
      x  = $urandom;
      y  = $urandom;
      op = 3'($urandom_range(0, 7));
      if (i % 8 == 0) y = x;
      if (i % 8 == 1) x = 32'h7FFF_FFFF;
      issue(x, y, op, lat, obs);
      tests++;
      if (lat !== exp_lat(op, y)) begin
        fails++; $display("FAIL rand_lat op=%0d b=%h got %0d want %0d", op, y, lat, exp_lat(op, y));
      end
      tests++;
      if (obs !== model(x, y, op)) begin
        fails++; $display("FAIL rand_res op=%0d a=%h b=%h got %h want %h", op, x, y, obs, model(x, y, op));
      end
      release_out();
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; opcode = '0;
    test_reset();
    test_directed(32'hFFFF_FFFF, 32'd1, 3'd0, {32'h0000_0000, 4'b1010}, 1);
    test_directed(32'h8000_0000, 32'd1, 3'd2, {32'h7FFF_FFFF, 4'b0001}, 1);
    test_directed(32'd3, 32'd5, 3'd2, {32'hFFFF_FFFE, 4'b0110}, 1);
`ifdef ALU_SEQ_BARREL_SHIFT_EN
    test_directed(32'd1, 32'd31, 3'd1, {32'h8000_0000, 4'b0100}, 1);
`else
    test_directed(32'd1, 32'd31, 3'd1, {32'h8000_0000, 4'b0100}, 32);
`endif
    test_directed(32'd1, 32'h20, 3'd1, {32'h0000_0001, 4'b0000}, 1);
    test_mul_stall();
    test_reset_mid_mul();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
